// File: rtl/atm_cell_fwd_core.sv
`default_nettype none
// ============================================================================
// atm_cell_fwd_core : UNI->NNI ATM cell forwarder (RR ingress, HEC check,
// VPI lookup/rewrite, multicast egress). Define ATM_FWD_STATS_EN for counters.
// Revision: 1.0
// ============================================================================
module atm_cell_fwd_core #(
  parameter  int NumRx         = 4,
  parameter  int NumTx         = 4,
  parameter  int TimeoutCycles = 256,
  parameter  int CntW          = 16,
  localparam int CellBits      = 424
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NumRx-1:0]          rx_valid,
  output logic [NumRx-1:0]          rx_ready,
  input  logic [NumRx*CellBits-1:0] rx_cell,
  output logic                      lut_rd_en,
  output logic [7:0]                lut_addr,
  input  logic [NumTx+11:0]         lut_data,
  output logic [NumTx-1:0]          tx_valid,
  input  logic [NumTx-1:0]          tx_ready,
  output logic [CellBits-1:0]       tx_cell,
  output logic [CntW-1:0]           cell_cnt,
  output logic [CntW-1:0]           hec_err_cnt,
  output logic [CntW-1:0]           drop_cnt
);

  localparam int PtrW = (NumRx > 1) ? $clog2(NumRx) : 1;
  localparam int TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEC_CHK = 2'd1,
    LOOKUP  = 2'd2,
    FWD     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NumTx-1:0]    pending_q, pending_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [CellBits-1:0] cell_q, cell_d;

  logic [NumRx-1:0]    grant;
  logic                grant_vld;
  logic [PtrW-1:0]     grant_idx;
  logic [PtrW-1:0]     hi_idx, lo_idx;
  logic                hi_vld, lo_vld;
  logic [CellBits-1:0] cell_sel;
  logic                accept;
  logic [NumTx-1:0]    pending_left;
  logic [NumTx-1:0]    lut_fwd;
  logic [11:0]         lut_vpi;
  logic                inc_cell, inc_hec, inc_drop;

  // CRC-8 x^8+x^2+x+1, MSB first, init 0, coset 0x55
  function automatic logic [7:0] hec_calc(input logic [31:0] hdr);
    logic [7:0] crc;
    crc = 8'h00;
    for (int b = 31; b >= 0; b--) begin
      if (crc[7] ^ hdr[b]) crc = {crc[6:0], 1'b0} ^ 8'h07;
      else                 crc = {crc[6:0], 1'b0};
    end
    return crc ^ 8'h55;
  endfunction

  // Lowest requester at or above rr_ptr wins, else lowest below it
  always_comb begin
    hi_vld   = 1'b0;
    lo_vld   = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    grant    = '0;
    cell_sel = '0;
    for (int i = NumRx - 1; i >= 0; i--) begin
      if (rx_valid[i]) begin
        if (i >= int'(rr_ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = PtrW'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = PtrW'(i);
        end
      end
    end
    grant_vld = hi_vld | lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
    for (int i = 0; i < NumRx; i++) begin
      grant[i] = grant_vld && (grant_idx == PtrW'(i));
      if (grant[i]) cell_sel = rx_cell[i*CellBits +: CellBits];
    end
  end

  assign rx_ready     = (rst_n && state_q == IDLE) ? grant : '0;
  assign accept       = |rx_ready;
  assign lut_fwd      = lut_data[NumTx+11:12];
  assign lut_vpi      = lut_data[11:0];
  assign pending_left = pending_q & ~tx_ready;
  assign tx_valid     = (state_q == FWD) ? pending_q : '0;
  assign tx_cell      = cell_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    pending_d = pending_q;
    tmo_d     = tmo_q;
    cell_d    = cell_q;
    lut_rd_en = 1'b0;
    lut_addr  = 8'h00;
    inc_cell  = 1'b0;
    inc_hec   = 1'b0;
    inc_drop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cell_d   = cell_sel;
          rr_ptr_d = (grant_idx == PtrW'(NumRx - 1)) ? '0 : grant_idx + PtrW'(1);
          inc_cell = 1'b1;
          state_d  = HEC_CHK;
        end
      end
      HEC_CHK: begin
        if (hec_calc(cell_q[423:392]) != cell_q[391:384]) begin
          inc_hec = 1'b1;
          state_d = IDLE;
        end else begin
          lut_rd_en = 1'b1;
          lut_addr  = cell_q[419:412];
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lut_fwd == '0) begin
          inc_drop = 1'b1;
          state_d  = IDLE;
        end else begin
          pending_d           = lut_fwd;
          cell_d[423:412]     = lut_vpi;
          cell_d[391:384]     = hec_calc({lut_vpi, cell_q[411:392]});
          tmo_d               = '0;
          state_d             = FWD;
        end
      end
      FWD: begin
        pending_d = pending_left;
        tmo_d     = tmo_q + TmoW'(1);
        if (pending_left == '0) begin
          state_d = IDLE;
        end else if (TimeoutCycles != 0 && tmo_q == TmoLast) begin
          pending_d = '0;
          inc_drop  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        pending_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      pending_q <= '0;
      tmo_q     <= '0;
      cell_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      tmo_q     <= tmo_d;
      cell_q    <= cell_d;
    end
  end

`ifdef ATM_FWD_STATS_EN
  logic [CntW-1:0] cell_cnt_q, cell_cnt_d;
  logic [CntW-1:0] hec_err_cnt_q, hec_err_cnt_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating increments
  always_comb begin
    cell_cnt_d    = cell_cnt_q;
    hec_err_cnt_d = hec_err_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    if (inc_cell && cell_cnt_q != '1)    cell_cnt_d    = cell_cnt_q + CntW'(1);
    if (inc_hec  && hec_err_cnt_q != '1) hec_err_cnt_d = hec_err_cnt_q + CntW'(1);
    if (inc_drop && drop_cnt_q != '1)    drop_cnt_d    = drop_cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cell_cnt_q    <= '0;
      hec_err_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      cell_cnt_q    <= cell_cnt_d;
      hec_err_cnt_q <= hec_err_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign cell_cnt    = cell_cnt_q;
  assign hec_err_cnt = hec_err_cnt_q;
  assign drop_cnt    = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = inc_cell ^ inc_hec ^ inc_drop;
  assign cell_cnt     = '0;
  assign hec_err_cnt  = '0;
  assign drop_cnt     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_atm_cell_fwd_core.sv
`default_nettype none
// ============================================================================
// tb_atm_cell_fwd_core : directed self-checking bench for atm_cell_fwd_core.
// Revision: 1.0
// ============================================================================
module tb_atm_cell_fwd_core;

  localparam int NRX = 4;
  localparam int NTX = 4;
  localparam int TMO = 8;
  localparam int CW  = 16;
  localparam int CB  = 424;

`ifdef ATM_FWD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRX-1:0]    rx_valid, rx_ready;
  logic [NRX*CB-1:0] rx_cell;
  logic              lut_rd_en;
  logic [7:0]        lut_addr;
  logic [NTX+11:0]   lut_data;
  logic [NTX-1:0]    tx_valid, tx_ready;
  logic [CB-1:0]     tx_cell;
  logic [CW-1:0]     cell_cnt, hec_err_cnt, drop_cnt;

  logic [NTX+11:0]   lut_mem [256];
  logic [CB-1:0]     cells [NRX];
  int                n_checks = 0;
  int                n_fail   = 0;

  atm_cell_fwd_core #(
    .NumRx(NRX), .NumTx(NTX), .TimeoutCycles(TMO), .CntW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_cell(rx_cell),
    .lut_rd_en(lut_rd_en), .lut_addr(lut_addr), .lut_data(lut_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_cell(tx_cell),
    .cell_cnt(cell_cnt), .hec_err_cnt(hec_err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous LUT: data valid the cycle after the read strobe
  always @(posedge clk) if (lut_rd_en) lut_data <= lut_mem[lut_addr];

  task automatic chk(input string tag, input logic [CB-1:0] got, input logic [CB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Remainder of header*x^8 by long division, then coset
  function automatic logic [7:0] ref_hec(input logic [31:0] h);
    logic [39:0] r;
    r = {h, 8'h00};
    for (int i = 39; i >= 8; i--) if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0] ^ 8'h55;
  endfunction

  function automatic logic [CB-1:0] mk_cell(input logic [7:0] vpi, input logic [15:0] vci,
                                            input logic [7:0] seed, input bit corrupt);
    logic [CB-1:0] c;
    logic [31:0]   h;
    h = {4'h0, vpi, vci, 4'h0};
    c = '0;
    c[423:392] = h;
    c[391:384] = ref_hec(h) ^ {7'b0, corrupt};
    for (int i = 0; i < 48; i++) c[383 - 8*i -: 8] = seed + 8'(i);
    return c;
  endfunction

  function automatic logic [CW-1:0] ecnt(input int n);
    return STATS ? CW'(n) : '0;
  endfunction

  initial begin
    logic [CB-1:0] idle_cell;
    for (int i = 0; i < 256; i++) lut_mem[i] = '0;
    lut_mem[8'h12] = {4'b0101, 12'hABC};

    // Reset
    rst_n = 1'b0; rx_valid = '1; rx_cell = '0; tx_ready = '1;
    step(); #1;
    chk("rst_rx_ready", CB'(rx_ready), '0);
    step(); #1;
    chk("rst_tx_valid", CB'(tx_valid), '0);
    chk("rst_lut_rd_en", CB'(lut_rd_en), '0);
    chk("rst_cell_cnt", CB'(cell_cnt), '0);
    rst_n = 1'b1; rx_valid = '0;
    step();

    // T1: good cell on rx0, VPI 0x12 -> ports 0,2 with VPI 0xABC
    cells[0] = mk_cell(8'h12, 16'h0034, 8'h10, 1'b0);
    rx_cell[0*CB +: CB] = cells[0];
    rx_valid = 4'b0001; #1;
    chk("t1_rx_ready", CB'(rx_ready), CB'(4'b0001));
    step(); rx_valid = '0; #1;
    chk("t1_lut_rd_en", CB'(lut_rd_en), CB'(1'b1));
    chk("t1_lut_addr", CB'(lut_addr), CB'(8'h12));
    chk("t1_no_tx_early", CB'(tx_valid), '0);
    step(); #1;
    chk("t1_lut_rd_off", CB'(lut_rd_en), '0);
    step(); #1;
    chk("t1_tx_valid", CB'(tx_valid), CB'(4'b0101));
    chk("t1_nni_vpi", CB'(tx_cell[423:412]), CB'(12'hABC));
    chk("t1_hec", CB'(tx_cell[391:384]), CB'(ref_hec({12'hABC, cells[0][411:392]})));
    chk("t1_payload", CB'(tx_cell[383:0]), CB'(cells[0][383:0]));
    chk("t1_cell_cnt", CB'(cell_cnt), CB'(ecnt(1)));
    step(); #1;
    chk("t1_tx_done", CB'(tx_valid), '0);

    // T2: bad HEC on rx1, new accept at T+2
    cells[1] = mk_cell(8'h12, 16'h0055, 8'h20, 1'b1);
    rx_cell[1*CB +: CB] = cells[1];
    rx_valid = 4'b0010; #1;
    chk("t2_rx_ready", CB'(rx_ready), CB'(4'b0010));
    step(); rx_valid = '0; #1;
    chk("t2_no_lut", CB'(lut_rd_en), '0);
    chk("t2_no_tx", CB'(tx_valid), '0);
    step();

    // T4: idle-cell header 00 00 00 01 (HEC 0x52), VPI 0 maps to fwd=0
    idle_cell = '0;
    idle_cell[423:384] = 40'h00_00_00_01_52;
    rx_cell[2*CB +: CB] = idle_cell;
    rx_valid = 4'b0100; #1;
    chk("t2_reaccept", CB'(rx_ready), CB'(4'b0100));
    chk("t2_hec_err_cnt", CB'(hec_err_cnt), CB'(ecnt(1)));
    step(); rx_valid = '0; #1;
    chk("t4_lut_rd_en", CB'(lut_rd_en), CB'(1'b1));
    chk("t4_lut_addr", CB'(lut_addr), '0);
    step(); #1;
    chk("t4_no_tx", CB'(tx_valid), '0);
    step(); #1;
    chk("t4_drop_cnt", CB'(drop_cnt), CB'(ecnt(1)));
    chk("t4_no_tx_after", CB'(tx_valid), '0);

    // T3: all ports requesting, rr_ptr now 3 -> order 3,0,1,2,3 back-to-back
    for (int p = 0; p < NRX; p++) begin
      cells[p] = mk_cell(8'h12, 16'h0100 + 16'(p), 8'h40 + 8'(16*p), 1'b0);
      rx_cell[p*CB +: CB] = cells[p];
    end
    rx_valid = '1; #1;
    for (int k = 0; k < 5; k++) begin
      int p;
      p = (3 + k) % NRX;
      chk("t3_grant", CB'(rx_ready), CB'(4'b0001) << p);
      step();
      if (k == 4) rx_valid = '0;
      #1;
      chk("t3_cell_cnt", CB'(cell_cnt), CB'(ecnt(4 + k)));
      step(); step(); #1;
      chk("t3_tx_valid", CB'(tx_valid), CB'(4'b0101));
      chk("t3_vci", CB'(tx_cell[411:396]), CB'(16'h0100 + 16'(p)));
      step(); #1;
    end

    // T5: port 2 stalls; abandoned after 8 FWD cycles
    tx_ready = 4'b1011;
    rx_valid = 4'b0001; #1;
    chk("t5_rx_ready", CB'(rx_ready), CB'(4'b0001));
    step(); rx_valid = '0;
    step(); step(); #1;
    chk("t5_first", CB'(tx_valid), CB'(4'b0101));
    step(); #1;
    chk("t5_port0_done", CB'(tx_valid), CB'(4'b0100));
    repeat (6) step();
    #1;
    chk("t5_hold", CB'(tx_valid), CB'(4'b0100));
    chk("t5_drop_before", CB'(drop_cnt), CB'(ecnt(1)));
    step(); #1;
    chk("t5_timeout", CB'(tx_valid), '0);
    chk("t5_drop_cnt", CB'(drop_cnt), CB'(ecnt(2)));
    tx_ready = '1;
    rx_valid = 4'b0010; #1;
    chk("t5_next_accept", CB'(rx_ready), CB'(4'b0010));
    step(); rx_valid = '0; tx_ready = '0;
    step(); step(); #1;

    // T6: reset during FWD
    chk("t6_pre_tx", CB'(tx_valid), CB'(4'b0101));
    chk("t6_pre_cell_cnt", CB'(cell_cnt), CB'(ecnt(10)));
    rst_n = 1'b0;
    step(); rst_n = 1'b1; #1;
    chk("t6_tx_valid", CB'(tx_valid), '0);
    chk("t6_cell_cnt", CB'(cell_cnt), '0);
    chk("t6_hec_err_cnt", CB'(hec_err_cnt), '0);
    chk("t6_drop_cnt", CB'(drop_cnt), '0);
    step(); #1;
    chk("t6_tx_stays_low", CB'(tx_valid), '0);

    // Rerun T1 after reset; rr_ptr must be back at 0
    tx_ready = '1;
    rx_valid = '1; #1;
    chk("t6_ptr_reset", CB'(rx_ready), CB'(4'b0001));
    step(); rx_valid = '0;
    step(); step(); #1;
    chk("t6_t1_tx_valid", CB'(tx_valid), CB'(4'b0101));
    chk("t6_t1_vpi", CB'(tx_cell[423:412]), CB'(12'hABC));
    chk("t6_t1_hec", CB'(tx_cell[391:384]), CB'(ref_hec({12'hABC, cells[0][411:392]})));
    chk("t6_t1_cell_cnt", CB'(cell_cnt), CB'(ecnt(1)));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
